// File: rtl/dsp_mac_bank_pkg.sv
// Shared definitions for the multi-channel MAC bank: op-code encoding and widths.
package dsp_mac_bank_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_MUL  = 2'd0,
      OP_MAC  = 2'd1,
      OP_MSUB = 2'd2,
      OP_CLR  = 2'd3
   } mac_op_e;

endpackage

// File: rtl/dsp_sat_shift.sv
// Arithmetic right shift of a wide signed value, then saturation to OW bits with a clip flag.
module dsp_sat_shift #(
   parameter int IW    = 48,
   parameter int OW    = 18,
   parameter int SHIFT = 17
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout,
   output logic                 ovf
);

   logic signed [IW-1:0] shifted;

   assign shifted = din >>> SHIFT;

   // The value fits in OW bits only if every bit above the OW-1 sign position copies the sign.
   // NOTE: every output gets a default first so no path through the block can infer a latch.
   always_comb begin
      dout = shifted[OW-1:0];
      ovf  = 1'b0;
      if (shifted[IW-1] && !(&shifted[IW-2:OW-1])) begin
         dout = {1'b1, {(OW-1){1'b0}}};
         ovf  = 1'b1;
      end else if (!shifted[IW-1] && (|shifted[IW-2:OW-1])) begin
         dout = {1'b0, {(OW-1){1'b1}}};
         ovf  = 1'b1;
      end
   end

endmodule

// File: rtl/dsp_mac_bank.sv
// NCH time-multiplexed accumulators sharing one 3-stage A/B -> M -> P multiply-accumulate pipeline.
module dsp_mac_bank
   import dsp_mac_bank_pkg::*;
#(
   parameter  int DW    = 18,
   parameter  int PW    = 48,
   parameter  int NCH   = 4,
   parameter  int SHIFT = 17,
   localparam int CHW   = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [OP_W-1:0]      in_op,
   input  logic [CHW-1:0]       in_ch,
   input  logic signed [DW-1:0] in_a,
   input  logic signed [DW-1:0] in_b,
   input  logic                 clear_all,
   output logic                 out_valid,
   output logic [CHW-1:0]       out_ch,
   output logic signed [PW-1:0] out_p,
   output logic signed [DW-1:0] out_q,
   output logic                 out_ovf
);

   localparam logic [CHW:0] NCH_L = NCH[CHW:0];

   logic                   s1_valid, s2_valid;
   mac_op_e                s1_op, s2_op;
   logic [CHW-1:0]         s1_ch, s2_ch;
   logic signed [DW-1:0]   s1_a, s1_b;
   logic signed [2*DW-1:0] s2_m;

   logic signed [PW-1:0]   acc [NCH];
   logic signed [PW-1:0]   z, m_ext, p;
   logic signed [DW-1:0]   q;
   logic                   q_ovf;

   // Channels beyond NCH (non-power-of-2 banks) are dropped here and never reach write-back.
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_MUL;
         s1_ch    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s2_valid <= 1'b0;
         s2_op    <= OP_MUL;
         s2_ch    <= '0;
         s2_m     <= '0;
      end else begin
         s1_valid <= in_valid && ({1'b0, in_ch} < NCH_L);
         s1_op    <= mac_op_e'(in_op);
         s1_ch    <= in_ch;
         s1_a     <= in_a;
         s1_b     <= in_b;
         s2_valid <= s1_valid;
         s2_op    <= s1_op;
         s2_ch    <= s1_ch;
         s2_m     <= s1_a * s1_b;
      end
   end

   // S3: the accumulator is read here, so a same-channel op one cycle behind sees this write.
   always_comb begin
      z     = acc[s2_ch];
      m_ext = PW'(s2_m);
      p     = '0;
      case (s2_op)
         OP_MUL:  p = m_ext;
         OP_MAC:  p = z + m_ext;
         OP_MSUB: p = z - m_ext;
         OP_CLR:  p = '0;
         default: p = '0;
      endcase
   end

   dsp_sat_shift #(
      .IW    (PW),
      .OW    (DW),
      .SHIFT (SHIFT)
   ) u_sat (
      .din  (p),
      .dout (q),
      .ovf  (q_ovf)
   );

   // NOTE: the bank is a flop array rather than RAM, so an asynchronous reset of every entry is legal.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
      end else if (clear_all) begin
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
      end else if (s2_valid) begin
         acc[s2_ch] <= p;
      end
   end

   // The result is still reported on a clear edge even though its write-back is discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_p     <= '0;
         out_q     <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= s2_valid;
         out_ovf   <= s2_valid && q_ovf;
         if (s2_valid) begin
            out_ch <= s2_ch;
            out_p  <= p;
            out_q  <= q;
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_bank.sv
// Scoreboard bench for dsp_mac_bank: a SHIFT=0 and a SHIFT=17 instance share one stimulus stream.
module tb_dsp_mac_bank;
   import dsp_mac_bank_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic [1:0]         in_op;
   logic [1:0]         in_ch;
   logic signed [17:0] in_a, in_b;
   logic               clear_all;

   logic               out_valid, v17;
   logic [1:0]         out_ch, ch17;
   logic signed [47:0] out_p, p17;
   logic signed [17:0] out_q, q17;
   logic               out_ovf, ovf17;

   dsp_mac_bank #(.DW(18), .PW(48), .NCH(4), .SHIFT(0)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op), .in_ch(in_ch),
      .in_a(in_a), .in_b(in_b), .clear_all(clear_all), .out_valid(out_valid),
      .out_ch(out_ch), .out_p(out_p), .out_q(out_q), .out_ovf(out_ovf)
   );

   dsp_mac_bank #(.DW(18), .PW(48), .NCH(4), .SHIFT(17)) dut17 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op), .in_ch(in_ch),
      .in_a(in_a), .in_b(in_b), .clear_all(clear_all), .out_valid(v17),
      .out_ch(ch17), .out_p(p17), .out_q(q17), .out_ovf(ovf17)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      int         ch;
      int         a;
      int         b;
      int         cyc;
   } sb_entry_t;

   sb_entry_t          sb[$];
   logic signed [47:0] model_acc [4];
   int                 cyc = 0;
   logic               clr_seen = 1'b0;
   int                 cmp_count = 0;
   int                 fail_count = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      cmp_count++;
      if (got !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void sat_model(input logic signed [47:0] p, input int sh,
                                     output longint q, output logic ovf);
      longint s;
      s = longint'(p) >>> sh;
      if (s > 131071) begin
         q = 131071;  ovf = 1'b1;
      end else if (s < -131072) begin
         q = -131072; ovf = 1'b1;
      end else begin
         q = s;       ovf = 1'b0;
      end
   endfunction

   always @(posedge clk) begin
      cyc      = cyc + 1;
      clr_seen = clear_all;
   end

   // Monitor: expected results come from a behavioural accumulator model, updated in issue order.
   always @(negedge clk) begin
      sb_entry_t          e;
      logic signed [47:0] m, z, p;
      longint             prod, q0, qs;
      logic               o0, os;
      if (reset_n) begin
         if (out_valid && sb.size() != 0) begin
            e    = sb.pop_front();
            prod = longint'(e.a) * longint'(e.b);
            m    = prod[47:0];
            z    = model_acc[e.ch];
            case (e.op)
               2'd0:    p = m;
               2'd1:    p = z + m;
               2'd2:    p = z - m;
               default: p = '0;
            endcase
            sat_model(p, 0, q0, o0);
            sat_model(p, 17, qs, os);
            check("out_p", out_p, p);
            check("out_ch", out_ch, e.ch);
            check("latency", cyc, e.cyc + 3);
            check("out_q", out_q, q0);
            check("out_ovf", out_ovf, o0);
            check("valid17", v17, 1);
            check("out_p17", p17, p);
            check("out_q17", q17, qs);
            check("out_ovf17", ovf17, os);
            model_acc[e.ch] = p;
         end else if (out_valid) begin
            check("spurious_valid", out_valid, 0);
         end else begin
            check("bubble_ovf", out_ovf, 0);
            check("bubble_valid17", v17, 0);
         end
         if (clr_seen) for (int i = 0; i < 4; i++) model_acc[i] = '0;
      end
   end

   task automatic issue(input logic [1:0] op, input int ch, input int a, input int b,
                        input logic clr = 1'b0);
      sb_entry_t e;
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_op     = op;
      in_ch     = ch[1:0];
      in_a      = a[17:0];
      in_b      = b[17:0];
      clear_all = clr;
      e.op = op; e.ch = ch; e.a = a; e.b = b; e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid  = 1'b0;
         clear_all = 1'b0;
      end
   endtask

   task automatic drain();
      idle(1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_ch = 2'd0;
      in_a = '0; in_b = '0; clear_all = 1'b0;
      for (int i = 0; i < 4; i++) model_acc[i] = '0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_p", out_p, 0);
      check("rst_q", out_q, 0);
      check("rst_ovf", out_ovf, 0);
      #20;
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Plain multiply, then MAC with b=0 exposes acc0.
      issue(OP_MUL, 0, 3, -5);
      drain();
      issue(OP_MAC, 0, 1, 0);
      drain();

      // Back-to-back MAC on one channel, then two interleaved channels.
      for (int i = 0; i < 4; i++) issue(OP_MAC, 1, 2, 3);
      for (int i = 0; i < 4; i++) issue(OP_MAC, 2 + (i % 2), (i % 2) ? 10 : 1, (i % 2) ? 10 : 1);
      drain();

      // Saturation corners, MSUB, CLR with nonzero operands.
      issue(OP_MUL, 0, 131071, 131071);
      issue(OP_MUL, 1, -131072, 131071);
      issue(OP_MSUB, 2, 4, 5);
      issue(OP_CLR, 3, 7, 9);
      issue(OP_MAC, 3, 1, 1);
      issue(OP_MUL, 0, 65536, 4);
      issue(OP_MSUB, 1, -131072, -131072);
      drain();

      // clear_all lands mid-stream on ch1.
      issue(OP_MUL, 1, 0, 0);
      for (int i = 0; i < 6; i++) issue(OP_MAC, 1, 2, 3, i == 3);
      drain();

      // Reset with ops in flight: nothing may emerge and every accumulator restarts at 0.
      for (int i = 0; i < 3; i++) issue(OP_MAC, i, 5, 5);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) model_acc[i] = '0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_p", out_p, 0);
      check("midrst_ch", out_ch, 0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      idle(5);
      for (int i = 0; i < 4; i++) issue(OP_MAC, i, 1, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
